// File: rtl/z_out_scheduler_if.sv
// Tile request channel between the Z output scheduler and the data_out sink streamer.
interface z_out_scheduler_if #(
    parameter int LEN_W = 4
);
    logic             req_valid_o;
    logic             req_ready_i;
    logic [31:0]      req_addr_o;
    logic [LEN_W-1:0] req_len_o;
    logic             req_last_o;

    modport master (
        output req_valid_o,
        output req_addr_o,
        output req_len_o,
        output req_last_o,
        input  req_ready_i
    );

    modport slave (
        input  req_valid_o,
        input  req_addr_o,
        input  req_len_o,
        input  req_last_o,
        output req_ready_i
    );
endinterface

// File: rtl/z_out_scheduler.sv
// Output-side address scheduler: walks matrix Z in row-major column tiles and
// issues one (address, length) write request per tile to the sink streamer.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start; parameters latched when start is honoured
// RUN       | presenting tile requests, one per handshake
// WAIT_SINK | all requests issued, waiting for the streamer to commit data
// DONE      | one-cycle done pulse, then back to IDLE

package accelerator_package;
    typedef struct packed {
        logic [31:0] base_address;
        logic [15:0] y_columns;
        logic [15:0] y_row_iters;
        logic [15:0] x_rows;
    } Z_param_t;
endpackage

module z_out_scheduler
    import accelerator_package::*;
#(
    parameter int TILE_ELEMS = 8,
    parameter int ELEM_BYTES = 4,
    parameter int LEN_W      = $clog2(TILE_ELEMS + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  Z_param_t                z_params_i,
    z_out_scheduler_if.master       req,
    input  logic                    sink_done_i,
    output logic                    busy_o,
    output logic                    done_o
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN       = 2'd1,
        S_WAIT_SINK = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    localparam logic [15:0] TILE_W     = 16'(TILE_ELEMS);
    localparam logic [31:0] TILE_BYTES = 32'(TILE_ELEMS * ELEM_BYTES);
    localparam int          EB_SHIFT   = $clog2(ELEM_BYTES);

    state_t           state_q, state_d;
    Z_param_t         params_q;
    logic [15:0]      row_cnt_q, tile_cnt_q;
    logic [15:0]      col_rem_q;
    logic [31:0]      row_base_q, tile_addr_q, stride_q;
    logic [LEN_W-1:0] len_q;
    logic             last_q;
    logic             sink_seen_q;

    logic             start_ok, empty_job, hs, tile_wrap;
    logic [15:0]      xr_m1, it_m1, row_cnt_inc, tile_cnt_inc, rem_sub;
    logic [31:0]      stride_start, row_base_nxt;

    // Remaining columns saturate at zero so an oversized y_row_iters yields
    // zero-length requests instead of wrapping.
    function automatic logic [LEN_W-1:0] len_of(input logic [15:0] rem);
        if (rem >= TILE_W)
            return LEN_W'(TILE_ELEMS);
        else
            return rem[LEN_W-1:0];
    endfunction

    assign start_ok     = (state_q == S_IDLE) && start_i;
    assign empty_job    = (z_params_i.x_rows == 16'd0) || (z_params_i.y_row_iters == 16'd0);
    assign hs           = (state_q == S_RUN) && req.req_ready_i;
    assign xr_m1        = params_q.x_rows - 16'd1;
    assign it_m1        = params_q.y_row_iters - 16'd1;
    assign tile_wrap    = !(tile_cnt_q < it_m1);
    assign row_cnt_inc  = row_cnt_q + 16'd1;
    assign tile_cnt_inc = tile_cnt_q + 16'd1;
    assign rem_sub      = (col_rem_q > TILE_W) ? (col_rem_q - TILE_W) : 16'd0;
    assign stride_start = 32'(z_params_i.y_columns) << EB_SHIFT;
    assign row_base_nxt = row_base_q + stride_q;

    // FSM state register; clear behaves exactly like reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= S_IDLE;
        else if (clear_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i)
                    state_d = empty_job ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (req.req_ready_i && last_q)
                    state_d = S_WAIT_SINK;
            end
            S_WAIT_SINK: begin
                if (sink_done_i || sink_seen_q)
                    state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; request fields come straight from the datapath registers.
    always_comb begin
        req.req_valid_o = (state_q == S_RUN);
        req.req_addr_o  = tile_addr_q;
        req.req_len_o   = len_q;
        req.req_last_o  = last_q;
        busy_o          = (state_q == S_RUN) || (state_q == S_WAIT_SINK);
        done_o          = (state_q == S_DONE);
    end

    // Tile walker: latch job on start, advance tile/row on every handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            params_q    <= '0;
            row_cnt_q   <= '0;
            tile_cnt_q  <= '0;
            col_rem_q   <= '0;
            row_base_q  <= '0;
            tile_addr_q <= '0;
            stride_q    <= '0;
            len_q       <= '0;
            last_q      <= 1'b0;
        end else if (clear_i) begin
            params_q    <= '0;
            row_cnt_q   <= '0;
            tile_cnt_q  <= '0;
            col_rem_q   <= '0;
            row_base_q  <= '0;
            tile_addr_q <= '0;
            stride_q    <= '0;
            len_q       <= '0;
            last_q      <= 1'b0;
        end else if (start_ok) begin
            params_q    <= z_params_i;
            row_cnt_q   <= '0;
            tile_cnt_q  <= '0;
            col_rem_q   <= z_params_i.y_columns;
            row_base_q  <= z_params_i.base_address;
            tile_addr_q <= z_params_i.base_address;
            stride_q    <= stride_start;
            len_q       <= len_of(z_params_i.y_columns);
            last_q      <= (z_params_i.x_rows == 16'd1) && (z_params_i.y_row_iters == 16'd1);
        end else if (hs) begin
            if (!tile_wrap) begin
                tile_cnt_q  <= tile_cnt_inc;
                tile_addr_q <= tile_addr_q + TILE_BYTES;
                col_rem_q   <= rem_sub;
                len_q       <= len_of(rem_sub);
                last_q      <= (row_cnt_q == xr_m1) && (tile_cnt_inc == it_m1);
            end else begin
                tile_cnt_q  <= '0;
                row_cnt_q   <= row_cnt_inc;
                row_base_q  <= row_base_nxt;
                tile_addr_q <= row_base_nxt;
                col_rem_q   <= params_q.y_columns;
                len_q       <= len_of(params_q.y_columns);
                last_q      <= (row_cnt_inc == xr_m1) && (it_m1 == 16'd0);
            end
        end
    end

    // Sticky capture of a sink_done that coincides with the final handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            sink_seen_q <= 1'b0;
        else if (clear_i)
            sink_seen_q <= 1'b0;
        else if (hs && last_q && sink_done_i)
            sink_seen_q <= 1'b1;
        else if (state_q == S_DONE || start_ok)
            sink_seen_q <= 1'b0;
    end

endmodule
